// File: rtl/lane_rr_sched.sv
// Five-lane round-robin scheduler feeding one shared transform datapath.
// Each transfer runs IDLE (arbitrate) -> CAPT (grant, capture) -> WRITE (update OUTi).
module lane_rr_sched #(
   parameter int unsigned WD = 4
) (
   input  logic          CLK,
   input  logic          RSTX,
   input  logic [4:0]    REQ,
   input  logic [WD-1:0] IN0,
   input  logic [WD-1:0] IN1,
   input  logic [WD-1:0] IN2,
   input  logic [WD-1:0] IN3,
   input  logic [WD-1:0] IN4,
   output logic [4:0]    GNT,
   output logic [WD-1:0] OUT0,
   output logic [WD-1:0] OUT1,
   output logic [WD-1:0] OUT2,
   output logic [WD-1:0] OUT3,
   output logic [WD-1:0] OUT4,
   output logic [4:0]    OVALID,
   output logic          BUSY
);

   typedef enum logic [1:0] {StIdle, StCapt, StWrite} state_e;

   state_e               state_q, state_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [2:0]           sel_q, sel_d;
   logic [WD-1:0]        stage_q, stage_d;
   logic [4:0]           gnt_q, gnt_d;
   logic [4:0]           ovalid_q, ovalid_d;
   logic [4:0][WD-1:0]   out_q, out_d;
   logic [4:0][WD-1:0]   in_arr;
   logic [2:0]           pick;
   logic [2:0]           idx;
   logic                 found;

   assign in_arr = {IN4, IN3, IN2, IN1, IN0};

   function automatic logic [WD-1:0] tf(input logic [WD-1:0] v);
      logic [WD-1:0] r;
      r[0] = v[0];
      for (int j = 1; j < int'(WD); j++) begin
         r[j] = ~v[j-1] ^ v[j];
      end
      return r;
   endfunction

   // First requesting lane at or after the pointer, wrapping 4 -> 0.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 0; k < 5; k++) begin
         if (!found && REQ[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      stage_d  = stage_q;
      gnt_d    = '0;
      ovalid_d = '0;
      out_d    = out_q;
      case (state_q)
         StIdle: begin
            if (found) begin
               sel_d   = pick;
               gnt_d   = 5'b00001 << pick;
               state_d = StCapt;
            end
         end
         StCapt: begin
            stage_d = in_arr[sel_q];
            state_d = StWrite;
         end
         StWrite: begin
            out_d[sel_q] = tf(stage_q);
            ovalid_d     = 5'b00001 << sel_q;
            ptr_d        = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         sel_q    <= '0;
         stage_q  <= '0;
         gnt_q    <= '0;
         ovalid_q <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         stage_q  <= stage_d;
         gnt_q    <= gnt_d;
         ovalid_q <= ovalid_d;
         out_q    <= out_d;
      end
   end

   assign GNT    = gnt_q;
   assign OVALID = ovalid_q;
   assign BUSY   = (state_q != StIdle);
   assign OUT0   = out_q[0];
   assign OUT1   = out_q[1];
   assign OUT2   = out_q[2];
   assign OUT3   = out_q[3];
   assign OUT4   = out_q[4];

endmodule

// File: doc/lane_rr_sched.md
LANE_RR_SCHED -- requirements
Module: lane_rr_sched

Interface
REQ-001 SHALL have parameter WD, default 4: width of each lane data word.
REQ-002 SHALL have lane count fixed at 5 (lanes 0..4); it is not a parameter.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RSTX  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  5  per-lane service request; bit i belongs to lane i.
REQ-006 IN0..IN4  input  WD each  per-lane operand.
REQ-007 GNT  output  5  registered one-hot grant; all-zero when nothing is granted.
REQ-008 OUT0..OUT4  output  WD each  registered per-lane transformed result.
REQ-009 OVALID  output  5  registered one-hot pulse marking an OUTi update.
REQ-010 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, CAPT and WRITE, with a single shared transform datapath.
REQ-012 SHALL hold a 3-bit round-robin pointer PTR in the range 0..4.
REQ-013 In IDLE, when REQ is nonzero, the FSM SHALL pick the first set bit searching PTR, PTR+1, ... mod 5, store the index in SEL, set GNT to onehot(SEL) and go to CAPT.
REQ-014 In IDLE, when REQ is zero, the FSM SHALL stay in IDLE with GNT equal to 0.
REQ-015 In CAPT (GNT high for exactly 1 cycle), the FSM SHALL capture IN[SEL] into the stage register, clear GNT and go to WRITE, whatever the current value of REQ.
REQ-016 In WRITE, the FSM SHALL load OUT[SEL] with TF(stage), pulse OVALID[SEL] for 1 cycle in step with the OUT update, set PTR to (SEL==4 ? 0 : SEL+1) and go to IDLE.
REQ-017 TF SHALL be: bit0 = in[0]; bit j = ~in[j-1] XOR in[j] for 1 <= j < WD; result is WD bits wide with no carry.
REQ-018 Latency: REQ first seen at edge N gives GNT high after edge N+1 and OUTi/OVALIDi updated after edge N+3. Each grant is 3 cycles apart.
REQ-019 Requester handshake: hold REQi and INi stable until the cycle GNTi is high. Drop REQi the cycle after GNTi unless another transfer is wanted.
REQ-020 REQi dropped before grant SHALL have no effect and SHALL NOT be remembered.
REQ-021 A REQ change during CAPT or WRITE SHALL NOT alter SEL; the pending transfer always completes.
REQ-022 OUTi for lanes not selected SHALL hold their value. OVALID SHALL be zero in all states except for the WRITE-exit pulse.
REQ-023 Simultaneous requests SHALL be resolved only by the PTR search. A lane just served has lowest priority in the next arbitration.
REQ-024 PTR SHALL wrap from 4 to 0. No lane SHALL wait more than 4 grants while its REQ is held.

Reset
REQ-025 RSTX low SHALL immediately force state IDLE, PTR=0, SEL=0, stage=0, GNT=0, OVALID=0, BUSY=0 and OUT0..OUT4=0.
REQ-026 Reset asserted mid-operation (CAPT or WRITE) SHALL abort the transfer with no OUT update. After reset release, the first arbitration SHALL start from PTR=0.

Verification
REQ-027 Reset: drive RSTX=0 with random REQ/IN -> every output 0 and BUSY=0. Release RSTX with REQ=0 -> state stays IDLE.
REQ-028 Single lane: REQ=5'b00100, IN2=4'h6 -> GNT=5'b00100 for 1 cycle, then OUT2=4'h4 and OVALID=5'b00100 for 1 cycle; BUSY high for 2 cycles.
REQ-029 Fairness: REQ=5'b11111 held after reset -> grant order 0,1,2,3,4,0,1 with GNT pulses 3 cycles apart.
REQ-030 Wrap: after lane 4 is served, REQ=5'b10001 -> lane 0 granted, then lane 4.
REQ-031 Mid-op reset: assert RSTX during CAPT for lane 3 -> GNT and BUSY drop immediately, OUT3 stays 0, no OVALID pulse.
REQ-032 Transform edges: IN0=4'h0 -> OUT0=4'hE; IN1=4'hF -> OUT1=4'hF. Unselected OUTs are unchanged throughout.
